// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel key debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } debounce_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: synchroniser, qualification FSM and stability counter.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Data,
    output logic o_Data,
    output logic o_Chk
);

    localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    debounce_state_t        state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   data_q, data_d;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            data_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_Data};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample disagreeing with the level under test drops back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        data_d  = data_q;
        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CntOne;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == CntMax) begin
                    state_d = IDLE_HI;
                    data_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CntOne;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                end else if (cnt_q == CntMax) begin
                    state_d = IDLE_LO;
                    data_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = IDLE_LO;
                data_d  = 1'b0;
            end
        endcase
    end

    assign o_Data = data_q;
    assign o_Chk  = (state_d == CHK_HI) || (state_d == CHK_LO);

endmodule

// File: rtl/debounce.sv
// Multi-channel key debouncer: N_CH independent channels plus a registered busy flag.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 8,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    input  logic [N_CH-1:0] i_Data,
    output logic [N_CH-1:0] o_Data,
    output logic            o_Busy
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce: STABLE_CYCLES must be >= 2");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("debounce: N_CH must be >= 1");
    end

    logic [N_CH-1:0] chk;
    logic            busy_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .i_Clk  (i_Clk),
            .i_Rst_n(i_Rst_n),
            .i_Data (i_Data[g]),
            .o_Data (o_Data[g]),
            .o_Chk  (chk[g])
        );
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |chk;
        end
    end

    assign o_Busy = busy_q;

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: directed latency checks plus a run-length reference model.
module tb_debounce;

    localparam int unsigned NCh = 2;
    localparam int unsigned St  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCh-1:0] din = '0;
    logic [NCh-1:0] o_data;
    logic           o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    debounce #(
        .N_CH         (NCh),
        .STABLE_CYCLES(St)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .i_Data (din),
        .o_Data (o_data),
        .o_Busy (o_busy)
    );

    initial forever #5 clk = ~clk;

    // Reference: the input reaches the qualifier two edges late; the output flips once
    // St consecutive delayed samples disagree with it, and busy means a run is open.
    logic [NCh-1:0] hist [3];
    int             run  [NCh];
    logic [NCh-1:0] m_o = '0;
    logic           m_busy = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        for (int c = 0; c < int'(NCh); c++) run[c] = 0;
        m_o    = '0;
        m_busy = 1'b0;
    endtask

    task automatic model_step();
        logic [NCh-1:0] s;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = din;
        s       = hist[2];
        m_busy  = 1'b0;
        for (int c = 0; c < int'(NCh); c++) begin
            if (s[c] != m_o[c]) begin
                run[c] = run[c] + 1;
                if (run[c] == int'(St)) begin
                    m_o[c] = s[c];
                    run[c] = 0;
                end
            end else begin
                run[c] = 0;
            end
            if (run[c] != 0) m_busy = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one input value for one edge, then compare against the model at the next negedge.
    task automatic cyc(input logic [NCh-1:0] d);
        din = d;
        @(negedge clk);
        check_eq("model_o_data", 32'(o_data), 32'(m_o));
        check_eq("model_o_busy", 32'(o_busy), 32'(m_busy));
    endtask

    task automatic settle(input logic [NCh-1:0] d);
        for (int i = 0; i < 10; i++) cyc(d);
    endtask

    initial begin
        @(negedge clk);
        // Reset with inputs high: outputs stay low throughout.
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11);
            check_eq("rst_o_data", 32'(o_data), 32'd0);
            check_eq("rst_o_busy", 32'(o_busy), 32'd0);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(2'b11);
            check_eq("rel_o_data", 32'(o_data), (e >= 6) ? 32'd3 : 32'd0);
        end

        settle(2'b00);
        check_eq("settle_low", 32'(o_data), 32'd0);

        // Clean press on ch0 captured at index 0.
        for (int i = 0; i <= 7; i++) begin
            cyc(2'b01);
            check_eq("press_o_data0", 32'(o_data[0]), (i >= 5) ? 32'd1 : 32'd0);
            check_eq("press_o_busy", 32'(o_busy), (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
        end

        // Release on ch0.
        for (int i = 0; i <= 7; i++) begin
            cyc(2'b00);
            check_eq("release_o_data0", 32'(o_data[0]), (i >= 5) ? 32'd0 : 32'd1);
        end

        // Three-cycle high glitch must not qualify.
        for (int i = 0; i < 12; i++) begin
            cyc((i < 3) ? 2'b01 : 2'b00);
            check_eq("glitch_o_data0", 32'(o_data[0]), 32'd0);
        end

        // Bounce 1,1,0,1,1,... : the last rising capture is index 3.
        for (int i = 0; i <= 10; i++) begin
            cyc((i == 2) ? 2'b00 : 2'b01);
            check_eq("bounce_o_data0", 32'(o_data[0]), (i >= 8) ? 32'd1 : 32'd0);
        end

        settle(2'b00);

        // Independent channels: ch0 at index 0, ch1 at index 2.
        for (int i = 0; i <= 9; i++) begin
            cyc((i >= 2) ? 2'b11 : 2'b01);
            check_eq("indep_o_data0", 32'(o_data[0]), (i >= 5) ? 32'd1 : 32'd0);
            check_eq("indep_o_data1", 32'(o_data[1]), (i >= 7) ? 32'd1 : 32'd0);
            check_eq("indep_o_busy", 32'(o_busy), (i >= 2 && i <= 6) ? 32'd1 : 32'd0);
        end

        settle(2'b00);

        // Reset in the middle of a press, input held high afterwards.
        for (int i = 0; i <= 3; i++) cyc(2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_o_data", 32'(o_data), 32'd0);
        check_eq("midrst_o_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        cyc(2'b01);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            cyc(2'b01);
            check_eq("midrst_rel_o_data0", 32'(o_data[0]), (e >= 6) ? 32'd1 : 32'd0);
        end

        // Random phase: sticky inputs with occasional flips and rare mid-cycle resets.
        begin
            logic [NCh-1:0] d;
            d = '0;
            for (int i = 0; i < 1500; i++) begin
                for (int c = 0; c < int'(NCh); c++) begin
                    if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
                end
                if ($urandom_range(0, 199) == 0) begin
                    #($urandom_range(1, 8)) rst_n = 1'b0;
                    #1;
                    check_eq("rand_rst_o_data", 32'(o_data), 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                cyc(d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
